// File: rtl/vga_timing_if.sv
// Raster timing bus driven by vga_timing and consumed by the draw stages.
// Every signal is registered at the source and describes a single (hcount, vcount) pair.
interface vga_timing_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk
  );
endinterface

// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters with registered sync and blank flags.
// Flags are decoded from the next-state counts so the counts and the flags never skew.
module vga_timing #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1
) (
  input  logic         pclk,
  input  logic         rst,
  vga_timing_if.master o_vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
    $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
  end

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  // Twelve-bit bounds so a raster of exactly 2048 does not alias to zero.
  localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hblnk;
  logic        r_vblnk;

  logic        w_h_last;
  logic [10:0] w_h_next;
  logic [10:0] w_v_next;
  logic        w_hsync_on;
  logic        w_vsync_on;
  logic        w_hblnk_next;
  logic        w_vblnk_next;

  always_comb begin
    w_h_last     = (r_hcount == H_LAST);
    w_h_next     = w_h_last ? 11'd0 : (r_hcount + 11'd1);
    w_v_next     = w_h_last ? ((r_vcount == V_LAST) ? 11'd0 : (r_vcount + 11'd1)) : r_vcount;
    w_hsync_on   = ({1'b0, w_h_next} >= HS_START) && ({1'b0, w_h_next} < HS_END);
    w_vsync_on   = ({1'b0, w_v_next} >= VS_START) && ({1'b0, w_v_next} < VS_END);
    w_hblnk_next = ({1'b0, w_h_next} >= H_ACT_END);
    w_vblnk_next = ({1'b0, w_v_next} >= V_ACT_END);
  end

  // Reset loads the raster state of position (0,0), so sync drops at once.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_hcount <= 11'd0;
      r_vcount <= 11'd0;
      r_hsync  <= ~H_SYNC_POL;
      r_vsync  <= ~V_SYNC_POL;
      r_hblnk  <= 1'b0;
      r_vblnk  <= 1'b0;
    end else begin
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      r_hsync  <= w_hsync_on ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync  <= w_vsync_on ? V_SYNC_POL : ~V_SYNC_POL;
      r_hblnk  <= w_hblnk_next;
      r_vblnk  <= w_vblnk_next;
    end
  end

  assign o_vga.hcount = r_hcount;
  assign o_vga.vcount = r_vcount;
  assign o_vga.hsync  = r_hsync;
  assign o_vga.vsync  = r_vsync;
  assign o_vga.hblnk  = r_hblnk;
  assign o_vga.vblnk  = r_vblnk;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 720p instance plus two tiny rasters (positive and negative sync).
// Stimulus pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_vga_timing;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  // Small raster: 8+2+3+4 = 17 pixels, 6+1+2+3 = 12 lines, 204 cycles per frame.
  localparam int BH_A = 8, BH_F = 2, BH_S = 3, BH_B = 4;
  localparam int BV_A = 6, BV_F = 1, BV_S = 2, BV_B = 3;

  vga_timing_if vif_a ();
  vga_timing_if vif_b ();
  vga_timing_if vif_c ();

  vga_timing u_a (.pclk(pclk), .rst(rst), .o_vga(vif_a));

  vga_timing #(.H_ACTIVE(BH_A), .H_FP(BH_F), .H_SYNC(BH_S), .H_BP(BH_B),
               .V_ACTIVE(BV_A), .V_FP(BV_F), .V_SYNC(BV_S), .V_BP(BV_B),
               .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1))
    u_b (.pclk(pclk), .rst(rst), .o_vga(vif_b));

  vga_timing #(.H_ACTIVE(BH_A), .H_FP(BH_F), .H_SYNC(BH_S), .H_BP(BH_B),
               .V_ACTIVE(BV_A), .V_FP(BV_F), .V_SYNC(BV_S), .V_BP(BV_B),
               .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0))
    u_c (.pclk(pclk), .rst(rst), .o_vga(vif_c));

  typedef struct packed {
    logic [25:0] a;
    logic [25:0] b;
    logic [25:0] c;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int pa_h = 0, pa_v = 0, pb_h = 0, pb_v = 0;
  int phase = 0;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] decode(input int h, input int v, input int ha, input int hf,
                                         input int hs, input int va, input int vf, input int vs,
                                         input bit hp, input bit vp);
    logic hsy, vsy, hbl, vbl;
    hsy = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
    vsy = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
    hbl = (h >= ha);
    vbl = (v >= va);
    return {11'(h), 11'(v), hsy, vsy, hbl, vbl};
  endfunction

  task automatic cmp6(input string tag, input logic [25:0] act, input logic [25:0] exp);
    check({tag, " hcount"}, act[25:15], exp[25:15]);
    check({tag, " vcount"}, act[14:4], exp[14:4]);
    check({tag, " hsync"}, {10'd0, act[3]}, {10'd0, exp[3]});
    check({tag, " vsync"}, {10'd0, act[2]}, {10'd0, exp[2]});
    check({tag, " hblnk"}, {10'd0, act[1]}, {10'd0, exp[1]});
    check({tag, " vblnk"}, {10'd0, act[0]}, {10'd0, exp[0]});
  endtask

  // One pclk edge with the given rst; expected state after the edge goes to the scoreboard.
  task automatic step(input logic r);
    exp_t e;
    rst = r;
    @(posedge pclk);
    if (r) begin
      pa_h = 0; pa_v = 0; pb_h = 0; pb_v = 0;
    end else begin
      pa_h++;
      if (pa_h == 1650) begin pa_h = 0; pa_v = (pa_v == 749) ? 0 : pa_v + 1; end
      pb_h++;
      if (pb_h == 17) begin pb_h = 0; pb_v = (pb_v == 11) ? 0 : pb_v + 1; end
    end
    e.a = decode(pa_h, pa_v, 1280, 110, 40, 720, 5, 5, 1'b1, 1'b1);
    e.b = decode(pb_h, pb_v, BH_A, BH_F, BH_S, BV_A, BV_F, BV_S, 1'b1, 1'b1);
    e.c = decode(pb_h, pb_v, BH_A, BH_F, BH_S, BV_A, BV_F, BV_S, 1'b0, 1'b0);
    sb_q.push_back(e);
    #1;
  endtask

  int cyc = 0;
  int hs_first = -1, hs_last = -1, hs_cnt = 0;
  int last00 = 0, vs_cnt = 0;
  bit moved = 1'b0, have_ref = 1'b0;
  logic prev_vs_b = 1'b0, prev_vs_c = 1'b1;

  // Scoreboard monitor plus line/frame measurements, sampled on the falling edge.
  always @(negedge pclk) begin
    exp_t e;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp6("A", {vif_a.hcount, vif_a.vcount, vif_a.hsync, vif_a.vsync, vif_a.hblnk, vif_a.vblnk}, e.a);
      cmp6("B", {vif_b.hcount, vif_b.vcount, vif_b.hsync, vif_b.vsync, vif_b.hblnk, vif_b.vblnk}, e.b);
      cmp6("C", {vif_c.hcount, vif_c.vcount, vif_c.hsync, vif_c.vsync, vif_c.hblnk, vif_c.vblnk}, e.c);
      if (vif_b.vsync !== prev_vs_b) check("B vsync edge hcount", vif_b.hcount, 11'd0);
      if (vif_c.vsync !== prev_vs_c) check("C vsync edge hcount", vif_c.hcount, 11'd0);
      prev_vs_b = vif_b.vsync;
      prev_vs_c = vif_c.vsync;
      if (phase == 0) begin
        if (vif_a.vcount == 11'd0 && vif_a.hsync === 1'b1) begin
          if (hs_first < 0) hs_first = int'(vif_a.hcount);
          hs_last = int'(vif_a.hcount);
          hs_cnt++;
        end
        if (vif_b.hcount != 11'd0 || vif_b.vcount != 11'd0) moved = 1'b1;
        if (vif_b.hcount == 11'd0 && vif_b.vcount == 11'd0 && moved) begin
          if (have_ref) begin
            check("B frame period", 11'(cyc - last00), 11'd204);
            check("B vsync cycles per frame", 11'(vs_cnt), 11'd34);
          end
          have_ref = 1'b1;
          last00 = cyc;
          vs_cnt = 0;
        end
        if (vif_b.vsync === 1'b1) vs_cnt++;
      end
    end
  end

  initial begin
    repeat (5) step(1'b1);
    check("reset A hsync", {10'd0, vif_a.hsync}, 11'd0);
    check("reset C hsync", {10'd0, vif_c.hsync}, 11'd1);
    step(1'b0);
    check("release A hcount", vif_a.hcount, 11'd1);
    check("release A vcount", vif_a.vcount, 11'd0);
    check("release A hblnk", {10'd0, vif_a.hblnk}, 11'd0);
    repeat (3320) step(1'b0);

    // Small raster: reset while at (11,7), inside both hsync and vsync.
    phase = 1;
    for (int i = 0; i < 300; i++) begin
      if (pb_h == 11 && pb_v == 7) break;
      step(1'b0);
    end
    check("B pre-reset hsync", {10'd0, vif_b.hsync}, 11'd1);
    check("B pre-reset vsync", {10'd0, vif_b.vsync}, 11'd1);
    step(1'b1);
    check("B post-reset hcount", vif_b.hcount, 11'd0);
    check("B post-reset vcount", vif_b.vcount, 11'd0);
    check("B post-reset hsync", {10'd0, vif_b.hsync}, 11'd0);
    check("B post-reset vsync", {10'd0, vif_b.vsync}, 11'd0);
    check("C post-reset hsync", {10'd0, vif_c.hsync}, 11'd1);
    check("C post-reset vsync", {10'd0, vif_c.vsync}, 11'd1);
    step(1'b0);
    check("B restart hcount", vif_b.hcount, 11'd1);
    check("B restart vcount", vif_b.vcount, 11'd0);

    // Default raster: reset in the middle of hsync.
    for (int i = 0; i < 1700; i++) begin
      if (pa_h == 1400) break;
      step(1'b0);
    end
    check("A pre-reset hsync", {10'd0, vif_a.hsync}, 11'd1);
    step(1'b1);
    check("A post-reset hsync", {10'd0, vif_a.hsync}, 11'd0);
    check("A post-reset hcount", vif_a.hcount, 11'd0);
    repeat (20) step(1'b0);
    @(negedge pclk);
    #1;

    check("A line0 hsync first", 11'(hs_first), 11'd1390);
    check("A line0 hsync last", 11'(hs_last), 11'd1429);
    check("A line0 hsync width", 11'(hs_cnt), 11'd40);
    check("scoreboard drained", 11'(sb_q.size()), 11'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
